bit_serializer: RTL
===================

BIT_SERIALIZER -- requirements
Module: bit_serializer

Interface
REQ-001 Parameter WIDTH, default 8, word length in bits; the block SHALL support WIDTH >= 2.
REQ-002 Parameter MSB_FIRST, default 1; 1 = bit WIDTH-1 is sent first, 0 = bit 0 is sent first.
REQ-003 Parameter GAP, default 0, number of idle cycles inserted after each word; range 0..15.
REQ-004 clk  input  1  clock; all state SHALL update on the rising edge.
REQ-005 reset  input  1  reset, asynchronous, active-high.
REQ-006 in_data  input  WIDTH  parallel word to serialize.
REQ-007 in_valid  input  1  in_data is valid.
REQ-008 in_ready  output  1  the block can accept a word this cycle.
REQ-009 dout  output  1  serial bit stream for the downstream pattern detector.
REQ-010 dout_valid  output  1  dout carries a data bit this cycle.
REQ-011 busy  output  1  the block is in the SHIFT or GAP state.
REQ-012 word_done  output  1  pulse asserted on the cycle the last bit of a word is on dout.

Function
REQ-013 The FSM SHALL have three states: IDLE, SHIFT and GAP.
REQ-014 A word SHALL be accepted only on a rising edge where in_valid=1 and in_ready=1; in_data SHALL be captured into an internal shift register at that edge.
REQ-015 in_ready SHALL be 1 in IDLE, and in SHIFT only on the last-bit cycle when GAP=0; it SHALL be 0 in all other cases.
REQ-016 Latency: the first bit of an accepted word SHALL appear on dout with dout_valid=1 in the cycle after the accept edge.
REQ-017 SHIFT SHALL present exactly WIDTH consecutive bits, one per cycle, in the order set by MSB_FIRST; dout_valid SHALL be 1 on all of them.
REQ-018 The bit counter SHALL be ceil(log2(WIDTH)) bits wide and SHALL count 0..WIDTH-1 with no wrap beyond WIDTH-1.
REQ-019 word_done SHALL be 1 exactly on the cycle with counter=WIDTH-1, and 0 otherwise.
REQ-020 Last-bit transition, GAP=0 with an accept: the state SHALL stay SHIFT, the counter SHALL clear, and the new word's first bit SHALL follow with no bubble.
REQ-021 Last-bit transition, GAP=0 with no accept: the state SHALL go to IDLE.
REQ-022 Last-bit transition, GAP>0: the state SHALL go to GAP for exactly GAP cycles and then to IDLE.
REQ-023 In IDLE and GAP, dout and dout_valid SHALL be 0.
REQ-024 Changes on in_data or in_valid while not accepting SHALL have no effect; a held in_valid SHALL be accepted at the next in_ready.
REQ-025 busy SHALL be 1 in SHIFT and GAP, and 0 in IDLE.
REQ-026 dout, dout_valid, word_done and busy SHALL be driven directly from flops or state decode, with no combinational path from in_data.

Reset
REQ-027 While reset=1, the block SHALL hold: state IDLE, counter 0, shift register 0, dout=0, dout_valid=0, word_done=0, busy=0, in_ready=0.
REQ-028 Reset asserted mid-word SHALL discard the word immediately with no further bits output; after reset release, in_ready SHALL be 1 in the first cycle.

Verification
REQ-029 MSB_FIRST=1: accept 0xA5 at cycle 0 -> cycles 1..8 dout=1,0,1,0,0,1,0,1, dout_valid=1, word_done only at cycle 8.
REQ-030 GAP=0, in_valid held with 0x55 then 0xAA -> 16 consecutive valid bits 0,1,0,1,0,1,0,1,1,0,1,0,1,0,1,0 with no dout_valid gap.
REQ-031 GAP=2, back-to-back words -> after the 8th bit, 2 cycles with dout_valid=0, busy=1 and in_ready=0; the next word is accepted in IDLE, and its first bit appears 4 cycles after the previous last bit.
REQ-032 MSB_FIRST=0: accept 0x01 -> dout=1 then seven 0s.
REQ-033 Reset pulse at the 4th bit of 0xFF -> dout and dout_valid go 0 immediately; after release, in_ready=1 and 0x0F serializes as 0,0,0,0,1,1,1,1.
REQ-034 in_data toggled every cycle during SHIFT -> the output bits match the word captured at accept.

Source files
------------

// File: rtl/bit_serializer.sv
// Parallel-to-serial shifter with a configurable idle gap after each word.
// A word is loaded on accept and shifted out one bit per cycle, starting the cycle after the accept.
//
// state    | meaning
// ST_IDLE  | waiting for a word, in_ready high
// ST_SHIFT | presenting WIDTH bits on dout, one per cycle
// ST_GAP   | GAP idle cycles after the last bit, no data out
module bit_serializer #(
    parameter int WIDTH     = 8,
    parameter bit MSB_FIRST = 1'b1,
    parameter int GAP       = 0
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] in_data,
    input  logic             in_valid,
    output logic             in_ready,
    output logic             dout,
    output logic             dout_valid,
    output logic             busy,
    output logic             word_done
);

    localparam int CW = $clog2(WIDTH);
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);
    localparam logic [3:0] GAP_LAST = (GAP > 0) ? 4'(GAP - 1) : 4'd0;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_SHIFT,
        ST_GAP
    } state_t;

    state_t           state_q, state_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [3:0]       gap_q, gap_d;
    logic [WIDTH-1:0] shreg_q, shreg_d;
    logic             last_bit;
    logic             accept;

    assign last_bit = (state_q == ST_SHIFT) && (cnt_q == LAST);
    // in_ready is held low during reset so nothing can be accepted while the block is cleared.
    assign in_ready = !reset && ((state_q == ST_IDLE) || ((GAP == 0) && last_bit));
    assign accept   = in_valid && in_ready;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        gap_d   = gap_q;
        shreg_d = shreg_q;
        case (state_q)
            ST_IDLE: begin
                if (accept) begin
                    state_d = ST_SHIFT;
                    cnt_d   = '0;
                    shreg_d = in_data;
                end
            end
            ST_SHIFT: begin
                if (last_bit) begin
                    if (accept) begin
                        cnt_d   = '0;
                        shreg_d = in_data;
                    end else if (GAP == 0) begin
                        state_d = ST_IDLE;
                    end else begin
                        state_d = ST_GAP;
                        gap_d   = GAP_LAST;
                    end
                end else begin
                    cnt_d   = cnt_q + CW'(1);
                    shreg_d = MSB_FIRST ? {shreg_q[WIDTH-2:0], 1'b0}
                                        : {1'b0, shreg_q[WIDTH-1:1]};
                end
            end
            ST_GAP: begin
                if (gap_q == 4'd0) begin
                    state_d = ST_IDLE;
                end else begin
                    gap_d = gap_q - 4'd1;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            gap_q   <= '0;
            shreg_q <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            gap_q   <= gap_d;
            shreg_q <= shreg_d;
        end
    end

    // Outputs come only from flops and state decode; in_data never reaches them combinationally.
    assign dout       = (state_q == ST_SHIFT) && (MSB_FIRST ? shreg_q[WIDTH-1] : shreg_q[0]);
    assign dout_valid = (state_q == ST_SHIFT);
    assign busy       = (state_q != ST_IDLE);
    assign word_done  = last_bit;

endmodule
